rtc_lectura_pantalla: RTL and testbench

- Bus-master read sequencer directly upstream of the VGA graphics stage.
- Sweeps the RTC's multiplexed address/data bus, reading 9 BCD registers: time, date and countdown timer.
- Captures all 9 into a shadow bank, then commits them atomically to output registers consumed by the number renderer.
- The screen therefore never shows a half-updated time.

---
 rtl/rtc_pkg.sv | 44 ++++
 rtl/contador_fase.sv | 21 ++
 rtl/rtc_lectura_pantalla.sv | 99 +++++++++
 tb/tb_rtc_lectura_pantalla.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared states, register indices and RTC address table for the display read sequencer
package rtc_pkg;

  localparam int N_REG     = 9;
  localparam int ANCHO_IDX = 4;

  typedef enum logic [2:0] {
    REPOSO,
    DIR,
    ESP1,
    DATO,
    ESP2,
    COMMIT
  } estado_t;

  localparam logic [ANCHO_IDX-1:0] IDX_SEG     = 4'd0;
  localparam logic [ANCHO_IDX-1:0] IDX_MIN     = 4'd1;
  localparam logic [ANCHO_IDX-1:0] IDX_HORA    = 4'd2;
  localparam logic [ANCHO_IDX-1:0] IDX_DIA     = 4'd3;
  localparam logic [ANCHO_IDX-1:0] IDX_MES     = 4'd4;
  localparam logic [ANCHO_IDX-1:0] IDX_ANIO    = 4'd5;
  localparam logic [ANCHO_IDX-1:0] IDX_CR_SEG  = 4'd6;
  localparam logic [ANCHO_IDX-1:0] IDX_CR_MIN  = 4'd7;
  localparam logic [ANCHO_IDX-1:0] IDX_CR_HORA = 4'd8;

  // RTC bus address for each shadow slot, in sweep order
  function automatic logic [7:0] dir_reg(input logic [ANCHO_IDX-1:0] idx);
    logic [7:0] d;
    case (idx)
      IDX_SEG:     d = 8'h21;
      IDX_MIN:     d = 8'h22;
      IDX_HORA:    d = 8'h23;
      IDX_DIA:     d = 8'h24;
      IDX_MES:     d = 8'h25;
      IDX_ANIO:    d = 8'h26;
      IDX_CR_SEG:  d = 8'h41;
      IDX_CR_MIN:  d = 8'h42;
      IDX_CR_HORA: d = 8'h43;
      default:     d = 8'h00;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/contador_fase.sv
// rtl/contador_fase.sv - bus phase counter with clear and terminal-count flag
module contador_fase #(
  parameter int T_PULSO = 10,
  parameter int ANCHO_T = 8
) (
  input  logic reloj,
  input  logic resetM,
  input  logic limpiar,
  output logic fin
);

  logic [ANCHO_T-1:0] cuenta;

  always_ff @(posedge reloj) begin
    if (resetM || limpiar) cuenta <= '0;
    else                   cuenta <= cuenta + 1'b1;
  end

  assign fin = (cuenta == ANCHO_T'(T_PULSO - 1));

endmodule

// File: rtl/rtc_lectura_pantalla.sv
// rtl/rtc_lectura_pantalla.sv - sweeps 9 RTC registers into a shadow bank and commits them atomically
module rtc_lectura_pantalla
  import rtc_pkg::*;
#(
  parameter int T_PULSO = 10,
  parameter int ANCHO_T = 8
) (
  input  logic        reloj,
  input  logic        resetM,
  input  logic        iniciar,
  input  logic [7:0]  dato_in,
  output logic [7:0]  dato_out,
  output logic        dato_oe,
  output logic        cs_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic        ad,
  output logic [23:0] hora,
  output logic [23:0] fecha,
  output logic [23:0] crono,
  output logic        ocupado,
  output logic        actualizado
);

  estado_t              estado, estado_sig;
  logic [ANCHO_IDX-1:0] indice;
  logic [7:0]           sombra [N_REG];
  logic                 fin, limpiar, ultimo;

  assign ultimo  = (indice == IDX_CR_HORA);
  // Every phase exit happens on fin, so clearing on fin restarts the count for the next phase
  assign limpiar = fin || (estado == REPOSO) || (estado == COMMIT);

  contador_fase #(.T_PULSO(T_PULSO), .ANCHO_T(ANCHO_T)) u_fase (
    .reloj   (reloj),
    .resetM  (resetM),
    .limpiar (limpiar),
    .fin     (fin)
  );

  always_ff @(posedge reloj) begin
    if (resetM) begin
      estado <= REPOSO;
      indice <= '0;
      hora   <= '0;
      fecha  <= '0;
      crono  <= '0;
      for (int i = 0; i < N_REG; i++) sombra[i] <= '0;
    end else begin
      estado <= estado_sig;
      if (estado == REPOSO && iniciar)         indice <= '0;
      if (estado == ESP2 && fin && !ultimo)    indice <= indice + 4'd1;
      if (estado == DATO && fin)               sombra[indice] <= dato_in;
      // Outputs update on the edge that enters COMMIT, so data is valid while actualizado is high
      if (estado == ESP2 && fin && ultimo) begin
        hora  <= {sombra[IDX_HORA],    sombra[IDX_MIN],    sombra[IDX_SEG]};
        fecha <= {sombra[IDX_DIA],     sombra[IDX_MES],    sombra[IDX_ANIO]};
        crono <= {sombra[IDX_CR_HORA], sombra[IDX_CR_MIN], sombra[IDX_CR_SEG]};
      end
    end
  end

  always_comb begin
    estado_sig = estado;
    cs_n       = 1'b1;
    rd_n       = 1'b1;
    wr_n       = 1'b1;
    ad         = 1'b0;
    dato_oe    = 1'b0;
    dato_out   = 8'h00;
    case (estado)
      REPOSO: if (iniciar) estado_sig = DIR;
      DIR: begin
        cs_n     = 1'b0;
        wr_n     = 1'b0;
        dato_oe  = 1'b1;
        dato_out = dir_reg(indice);
        if (fin) estado_sig = ESP1;
      end
      ESP1: if (fin) estado_sig = DATO;
      DATO: begin
        cs_n = 1'b0;
        rd_n = 1'b0;
        ad   = 1'b1;
        if (fin) estado_sig = ESP2;
      end
      ESP2: begin
        ad = 1'b1;
        if (fin) estado_sig = ultimo ? COMMIT : DIR;
      end
      COMMIT:  estado_sig = REPOSO;
      default: estado_sig = REPOSO;
    endcase
  end

  assign ocupado     = (estado != REPOSO);
  assign actualizado = (estado == COMMIT);

endmodule

// File: tb/tb_rtc_lectura_pantalla.sv
// tb/tb_rtc_lectura_pantalla.sv - scoreboard bench with RTC bus model for rtc_lectura_pantalla
module tb_rtc_lectura_pantalla;

  localparam int TP2 = 2;
  localparam int TP3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ini;
  logic [7:0]  din2, dout2, din3, dout3;
  logic        oe2, cs_n2, rd_n2, wr_n2, ad2, ocupado2, act2;
  logic        oe3, cs_n3, rd_n3, wr_n3, ad3, ocupado3, act3;
  logic [23:0] hora2, fecha2, crono2, hora3, fecha3, crono3;

  rtc_lectura_pantalla #(.T_PULSO(TP2), .ANCHO_T(8)) dut2 (
    .reloj(clk), .resetM(rst), .iniciar(ini), .dato_in(din2), .dato_out(dout2),
    .dato_oe(oe2), .cs_n(cs_n2), .rd_n(rd_n2), .wr_n(wr_n2), .ad(ad2),
    .hora(hora2), .fecha(fecha2), .crono(crono2), .ocupado(ocupado2), .actualizado(act2)
  );

  rtc_lectura_pantalla #(.T_PULSO(TP3), .ANCHO_T(8)) dut3 (
    .reloj(clk), .resetM(rst), .iniciar(ini), .dato_in(din3), .dato_out(dout3),
    .dato_oe(oe3), .cs_n(cs_n3), .rd_n(rd_n3), .wr_n(wr_n3), .ad(ad3),
    .hora(hora3), .fecha(fecha3), .crono(crono3), .ocupado(ocupado3), .actualizado(act3)
  );

  // RTC chip model: latches the address in the write window, returns mem on read, garbage otherwise
  logic [7:0] mem [0:255];
  logic [7:0] lat2 = 8'h00, lat3 = 8'h00, junk = 8'h5a;
  always @(posedge clk) begin
    junk <= 8'($urandom);
    if (!cs_n2 && !wr_n2) lat2 <= dout2;
    if (!cs_n3 && !wr_n3) lat3 <= dout3;
  end
  assign din2 = (!cs_n2 && !rd_n2) ? mem[lat2] : junk;
  assign din3 = (!cs_n3 && !rd_n3) ? mem[lat3] : junk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [71:0] act, logic [71:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, expv, cyc);
    end
  endfunction

  typedef struct {
    logic [23:0] h;
    logic [23:0] f;
    logic [23:0] c;
    int          t;
  } exp_t;

  exp_t        q[$];
  logic [71:0] cur = '0;
  logic [7:0]  tab [0:8];

  function automatic exp_t model(int t);
    exp_t e;
    e.h = {mem[8'h23], mem[8'h22], mem[8'h21]};
    e.f = {mem[8'h24], mem[8'h25], mem[8'h26]};
    e.c = {mem[8'h43], mem[8'h42], mem[8'h41]};
    e.t = t + 36 * TP2 + 1;
    return e;
  endfunction

  // Monitor: scoreboard for dut2, bus-window timing for dut3, contention on both
  logic prev_act2 = 1'b0;
  logic prev_cs3  = 1'b1;
  int   lowrun = 0, highrun = 0, nwin = 0;
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      cur       = '0;
      prev_act2 = 1'b0;
      prev_cs3  = 1'b1;
      lowrun    = 0;
      highrun   = 0;
      nwin      = 0;
    end else begin
      chk("contention2", 72'(oe2 & ~rd_n2), 72'(0));
      chk("contention3", 72'(oe3 & ~rd_n3), 72'(0));
      if (act2) begin
        chk("pulse_width", 72'(prev_act2), 72'(0));
        if (q.size() == 0) begin
          chk("spurious_commit", 72'(1), 72'(0));
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("hora",    72'(hora2),  72'(e.h));
          chk("fecha",   72'(fecha2), 72'(e.f));
          chk("crono",   72'(crono2), 72'(e.c));
          chk("latency", 72'(cyc),    72'(e.t));
          cur = {e.h, e.f, e.c};
        end
      end else begin
        chk("hold", {hora2, fecha2, crono2}, cur);
      end
      prev_act2 = act2;

      if (!cs_n3) begin
        if (prev_cs3) begin
          if (nwin > 0) chk("gap3", 72'(highrun), 72'(TP3));
          nwin++;
          lowrun = 0;
        end
        lowrun++;
        if (!wr_n3) chk("dir_addr3", 72'({oe3, dout3}), 72'({1'b1, tab[(nwin - 1) / 2]}));
      end else begin
        if (!prev_cs3) begin
          chk("win_len3", 72'(lowrun), 72'(TP3));
          highrun = 0;
        end
        highrun++;
        if (!ocupado3) nwin = 0;
      end
      prev_cs3 = cs_n3;
    end
  end

  task automatic start();
    @(posedge clk); #1;
    ini = 1'b1;
    q.push_back(model(cyc));
    @(posedge clk); #1;
    ini = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((ocupado2 || ocupado3) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 72'(n < 500), 72'(1));
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 9; i++) mem[tab[i]] = 8'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int n, nr;
    logic prevrd;
    tab[0] = 8'h21; tab[1] = 8'h22; tab[2] = 8'h23;
    tab[3] = 8'h24; tab[4] = 8'h25; tab[5] = 8'h26;
    tab[6] = 8'h41; tab[7] = 8'h42; tab[8] = 8'h43;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    rst = 1'b1;
    ini = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    repeat (100) begin
      @(negedge clk);
      chk("idle_bus", 72'({cs_n2, rd_n2, wr_n2, oe2, ocupado2, cs_n3, oe3, ocupado3}), 72'(8'b11100100));
    end
    chk("idle_out", {hora2, fecha2, crono2}, 72'(0));

    mem[8'h21] = 8'h45; mem[8'h22] = 8'h30; mem[8'h23] = 8'h12;
    mem[8'h24] = 8'h07; mem[8'h25] = 8'h03; mem[8'h26] = 8'h24;
    mem[8'h41] = 8'h05; mem[8'h42] = 8'h10; mem[8'h43] = 8'h01;
    start();
    wait_idle();
    chk("sweep1_values", {hora2, fecha2, crono2}, 72'h123045_070324_011005);

    rand_mem();
    start();
    repeat (4) @(posedge clk);
    #1 ini = 1'b1;
    @(posedge clk); #1 ini = 1'b0;
    wait_idle();

    rand_mem();
    start();
    n = 0;
    while (!act2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_commit", 72'(act2), 72'(1));
    ini = 1'b1;
    @(posedge clk); #1 ini = 1'b0;
    repeat (3) @(negedge clk);
    chk("commit_ini_ignored", 72'(ocupado2), 72'(0));
    wait_idle();

    rand_mem();
    start();
    n = 0; nr = 0; prevrd = 1'b1;
    while (nr < 5 && n < 300) begin
      @(negedge clk);
      if (!rd_n2 && prevrd) nr++;
      prevrd = rd_n2;
      n++;
    end
    chk("reach_dato4", 72'(nr), 72'(5));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("rst_bus", 72'({cs_n2, rd_n2, wr_n2, oe2, ad2, ocupado2, act2, cs_n3, ocupado3}), 72'(9'b111000010));
    chk("rst_out", {hora2, fecha2, crono2}, 72'(0));
    wait_idle();
    rand_mem();
    start();
    wait_idle();

    for (int s = 0; s < 4; s++) begin
      rand_mem();
      repeat ($urandom_range(0, 20)) @(posedge clk);
      start();
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 60)) @(posedge clk);
        #1 ini = 1'b1;
        @(posedge clk); #1 ini = 1'b0;
      end
      wait_idle();
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", 72'(q.size()), 72'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
